// File: rtl/io_pkg.sv
// Shared types for the buffered Sextium III I/O port: FSM state encoding and status bit layout.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ACK   = 2'd1,
        WR_ACK   = 2'd2,
        WAIT_REL = 2'd3
    } io_state_t;

    localparam int STAT_UNDERRUN = 0;
    localparam int STAT_OVERRUN  = 1;
    localparam int STAT_PROTO    = 2;
    localparam int STAT_W        = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; push ignored when full, pop ignored when empty.
// Zero-latency head (first-word fall-through); count changes on the edge after push/pop.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];
    assign w_push     = i_push & ~o_full;
    assign w_pop      = i_pop & ~o_empty;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/buffered_io_port.sv
// Sextium III I/O bus port with host-side input/output FIFOs; ioack is registered (1 cycle after request).
// BLOCKING=1 withholds ioack while the needed FIFO is empty/full; BLOCKING=0 acks at once and flags a sticky error.
module buffered_io_port
    import io_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               IN_DEPTH     = 16,
    parameter int               OUT_DEPTH    = 16,
    parameter int               BLOCKING     = 1,
    parameter logic [WIDTH-1:0] UNDERRUN_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       io_read,
    input  logic                       io_write,
    input  logic [WIDTH-1:0]           io_wdata,
    output logic [WIDTH-1:0]           io_rdata,
    output logic                       io_rdata_oe,
    output logic                       ioack,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(IN_DEPTH):0]  in_count,
    output logic [$clog2(OUT_DEPTH):0] out_count,
    output logic [STAT_W-1:0]          status,
    input  logic                       status_clr
);

    io_state_t         r_state;
    io_state_t         w_state_nxt;
    logic [WIDTH-1:0]  r_rdata;
    logic [WIDTH-1:0]  w_rdata_nxt;
    logic              r_ioack;
    logic              r_rdata_oe;
    logic [STAT_W-1:0] r_status;
    logic [STAT_W-1:0] w_status_set;

    logic              w_in_pop;
    logic [WIDTH-1:0]  w_in_head;
    logic              w_in_full;
    logic              w_in_empty;
    logic              w_out_push;
    logic              w_out_full;
    logic              w_out_empty;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (in_valid & ~w_in_full),
        .i_push_dat (in_data),
        .i_pop      (w_in_pop),
        .o_head_dat (w_in_head),
        .o_full     (w_in_full),
        .o_empty    (w_in_empty),
        .o_count    (in_count)
    );

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_out_push),
        .i_push_dat (io_wdata),
        .i_pop      (out_ready & ~w_out_empty),
        .o_head_dat (out_data),
        .o_full     (w_out_full),
        .o_empty    (w_out_empty),
        .o_count    (out_count)
    );

    assign in_ready    = ~w_in_full;
    assign out_valid   = ~w_out_empty;
    assign io_rdata    = r_rdata;
    assign io_rdata_oe = r_rdata_oe;
    assign ioack       = r_ioack;
    assign status      = r_status;

    // FIFO actions happen only on the IDLE exit, so a held strobe never repeats them.
    always_comb begin
        w_state_nxt  = r_state;
        w_rdata_nxt  = r_rdata;
        w_in_pop     = 1'b0;
        w_out_push   = 1'b0;
        w_status_set = '0;
        case (r_state)
            IDLE: begin
                if (io_read && io_write) begin
                    w_status_set[STAT_PROTO] = 1'b1;
                    w_state_nxt              = WAIT_REL;
                end else if (io_read) begin
                    if (!w_in_empty) begin
                        w_rdata_nxt = w_in_head;
                        w_in_pop    = 1'b1;
                        w_state_nxt = RD_ACK;
                    end else if (BLOCKING == 0) begin
                        w_rdata_nxt                 = UNDERRUN_VAL;
                        w_status_set[STAT_UNDERRUN] = 1'b1;
                        w_state_nxt                 = RD_ACK;
                    end
                end else if (io_write) begin
                    if (!w_out_full) begin
                        w_out_push  = 1'b1;
                        w_state_nxt = WR_ACK;
                    end else if (BLOCKING == 0) begin
                        w_status_set[STAT_OVERRUN] = 1'b1;
                        w_state_nxt                = WR_ACK;
                    end
                end
            end
            RD_ACK: begin
                if (!io_read) begin
                    w_state_nxt = IDLE;
                end
            end
            WR_ACK: begin
                if (!io_write) begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_REL: begin
                if (!io_read && !io_write) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rdata    <= '0;
            r_ioack    <= 1'b0;
            r_rdata_oe <= 1'b0;
            r_status   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rdata    <= w_rdata_nxt;
            r_ioack    <= (w_state_nxt == RD_ACK) || (w_state_nxt == WR_ACK);
            r_rdata_oe <= (w_state_nxt == RD_ACK);
            // A set event in the same cycle as the clear takes priority.
            r_status   <= (status_clr ? '0 : r_status) | w_status_set;
        end
    end

endmodule

// File: tb/tb_buffered_io_port.sv
// Bench for buffered_io_port: blocking instance (depth 16) and non-blocking instance (depth 4).
module tb_buffered_io_port;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        io_read, io_write, io_rdata_oe, ioack;
    logic [15:0] io_wdata, io_rdata;
    logic        in_valid, in_ready, out_valid, out_ready, status_clr;
    logic [15:0] in_data, out_data;
    logic [4:0]  in_count, out_count;
    logic [2:0]  status;

    logic        nb_read, nb_write, nb_rdata_oe, nb_ack;
    logic [15:0] nb_wdata, nb_rdata;
    logic        nb_in_valid, nb_in_ready, nb_out_valid, nb_out_ready, nb_clr;
    logic [15:0] nb_in_data, nb_out_data;
    logic [2:0]  nb_in_count, nb_out_count;
    logic [2:0]  nb_status;

    buffered_io_port #(.WIDTH(16), .IN_DEPTH(16), .OUT_DEPTH(16), .BLOCKING(1)) u_dut (
        .clk(clk), .reset(reset), .io_read(io_read), .io_write(io_write), .io_wdata(io_wdata),
        .io_rdata(io_rdata), .io_rdata_oe(io_rdata_oe), .ioack(ioack),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .in_count(in_count), .out_count(out_count), .status(status), .status_clr(status_clr)
    );

    buffered_io_port #(.WIDTH(16), .IN_DEPTH(4), .OUT_DEPTH(4), .BLOCKING(0)) u_dut_nb (
        .clk(clk), .reset(reset), .io_read(nb_read), .io_write(nb_write), .io_wdata(nb_wdata),
        .io_rdata(nb_rdata), .io_rdata_oe(nb_rdata_oe), .ioack(nb_ack),
        .in_valid(nb_in_valid), .in_data(nb_in_data), .in_ready(nb_in_ready),
        .out_valid(nb_out_valid), .out_data(nb_out_data), .out_ready(nb_out_ready),
        .in_count(nb_in_count), .out_count(nb_out_count), .status(nb_status), .status_clr(nb_clr)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [15:0] d);
        int n;
        n = 0;
        io_write = 1'b1;
        io_wdata = d;
        tick();
        while (!ioack && n < 50) begin
            tick();
            n++;
        end
        check("wr_ack", ioack, 1);
        io_write = 1'b0;
        tick();
    endtask

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        rd;
        logic        wr;
        logic [15:0] wd;
        logic        ordy;
        logic        clr;
        logic        e_ack;
        logic [15:0] e_rdata;
        logic [4:0]  e_inc;
        logic [4:0]  e_outc;
        logic [2:0]  e_st;
    } vec_t;

    vec_t tbl [15];

    logic [15:0] q_in  [$];
    logic [15:0] q_out [$];
    logic [15:0] exp_w;
    int          cpu_op;
    int          wait_cnt;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        {io_read, io_write, in_valid, out_ready, status_clr} = '0;
        io_wdata = '0; in_data = '0;
        {nb_read, nb_write, nb_in_valid, nb_out_ready, nb_clr} = '0;
        nb_wdata = '0; nb_in_data = '0;
        tick(); tick();
        reset = 1'b0;

        check("rst_ack", ioack, 0);
        check("rst_oe", io_rdata_oe, 0);
        check("rst_rdata", io_rdata, 0);
        check("rst_in_count", in_count, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_status", status, 0);
        check("rst_nb_in_ready", nb_in_ready, 1);

        // Host push + two reads, then simultaneous strobes and a clean write.
        //            iv  id        rd wr wd        ordy clr  ack rdata     inc outc st
        tbl[0]  = '{1'b1, 16'h1234, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 1, 0, 3'd0};
        tbl[1]  = '{1'b1, 16'hBEEF, 0, 0, 16'h0000, 0, 0,   0, 16'h0000, 2, 0, 3'd0};
        tbl[2]  = '{1'b0, 16'h0000, 1, 0, 16'h0000, 0, 0,   1, 16'h1234, 1, 0, 3'd0};
        tbl[3]  = '{1'b0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'h1234, 1, 0, 3'd0};
        tbl[4]  = '{1'b0, 16'h0000, 1, 0, 16'h0000, 0, 0,   1, 16'hBEEF, 0, 0, 3'd0};
        tbl[5]  = '{1'b0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'hBEEF, 0, 0, 3'd0};
        tbl[6]  = '{1'b0, 16'h0000, 1, 1, 16'h7777, 0, 0,   0, 16'hBEEF, 0, 0, 3'd4};
        tbl[7]  = '{1'b0, 16'h0000, 1, 1, 16'h7777, 0, 0,   0, 16'hBEEF, 0, 0, 3'd4};
        tbl[8]  = '{1'b0, 16'h0000, 0, 1, 16'h7777, 0, 0,   0, 16'hBEEF, 0, 0, 3'd4};
        tbl[9]  = '{1'b0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'hBEEF, 0, 0, 3'd4};
        tbl[10] = '{1'b0, 16'h0000, 0, 1, 16'h5555, 0, 0,   1, 16'hBEEF, 0, 1, 3'd4};
        tbl[11] = '{1'b0, 16'h0000, 0, 1, 16'h5555, 0, 0,   1, 16'hBEEF, 0, 1, 3'd4};
        tbl[12] = '{1'b0, 16'h0000, 0, 0, 16'h0000, 0, 0,   0, 16'hBEEF, 0, 1, 3'd4};
        tbl[13] = '{1'b0, 16'h0000, 0, 0, 16'h0000, 1, 0,   0, 16'hBEEF, 0, 0, 3'd4};
        tbl[14] = '{1'b0, 16'h0000, 0, 0, 16'h0000, 0, 1,   0, 16'hBEEF, 0, 0, 3'd0};

        for (int i = 0; i < 15; i++) begin
            in_valid = tbl[i].iv; in_data = tbl[i].id;
            io_read = tbl[i].rd; io_write = tbl[i].wr; io_wdata = tbl[i].wd;
            out_ready = tbl[i].ordy; status_clr = tbl[i].clr;
            if (i == 12) check("tbl_out_data", out_data, 16'h5555);
            tick();
            check($sformatf("tbl%0d_ack", i), ioack, tbl[i].e_ack);
            check($sformatf("tbl%0d_oe", i), io_rdata_oe, tbl[i].e_ack & tbl[i].rd);
            check($sformatf("tbl%0d_rdata", i), io_rdata, tbl[i].e_rdata);
            check($sformatf("tbl%0d_in_count", i), in_count, tbl[i].e_inc);
            check($sformatf("tbl%0d_out_count", i), out_count, tbl[i].e_outc);
            check($sformatf("tbl%0d_status", i), status, tbl[i].e_st);
        end
        {in_valid, io_read, io_write, out_ready, status_clr} = '0;

        // Blocking read on an empty FIFO stalls until the host supplies a word.
        io_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_rd_ack", ioack, 0);
        end
        in_valid = 1'b1; in_data = 16'h00AA;
        tick();
        check("stall_rd_push_edge_ack", ioack, 0);
        in_valid = 1'b0;
        tick();
        check("stall_rd_ack_rise", ioack, 1);
        check("stall_rd_rdata", io_rdata, 16'h00AA);
        check("stall_rd_status", status, 0);
        io_read = 1'b0;
        tick();

        // Fill the output FIFO; the 17th write waits for one host pop.
        for (int i = 0; i < 16; i++) cpu_write(16'(i));
        check("full_out_count", out_count, 16);
        io_write = 1'b1; io_wdata = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("full_wr_stall", ioack, 0);
        end
        check("full_head", out_data, 16'h0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_pop_edge_ack", ioack, 0);
        tick();
        check("full_wr_ack", ioack, 1);
        check("full_refill_count", out_count, 16);
        io_write = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_w = (i < 15) ? 16'(i + 1) : 16'hFFFF;
            check($sformatf("drain%0d", i), out_data, exp_w);
            tick();
        end
        out_ready = 1'b0;
        check("drain_empty", out_count, 0);

        // Reset in RD_ACK with the read strobe held high.
        in_valid = 1'b1; in_data = 16'h0011; tick();
        in_data = 16'h0022; tick();
        in_valid = 1'b0;
        io_read = 1'b1;
        tick();
        check("rstmid_ack_before", ioack, 1);
        check("rstmid_in_count_before", in_count, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_ack", ioack, 0);
        check("rstmid_in_count", in_count, 0);
        check("rstmid_out_count", out_count, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstmid_stall", ioack, 0);
        end
        in_valid = 1'b1; in_data = 16'h0042;
        tick();
        in_valid = 1'b0;
        tick();
        check("rstmid_served_ack", ioack, 1);
        check("rstmid_served_rdata", io_rdata, 16'h0042);
        io_read = 1'b0;
        tick();

        // Non-blocking instance: underrun, overrun with drop, clear semantics.
        nb_in_valid = 1'b1; nb_in_data = 16'h3C3C; tick();
        nb_in_valid = 1'b0;
        check("nb_in_count", nb_in_count, 1);
        nb_read = 1'b1; tick();
        check("nb_rd_ack", nb_ack, 1);
        check("nb_rd_rdata", nb_rdata, 16'h3C3C);
        nb_read = 1'b0; tick();
        nb_read = 1'b1; tick();
        check("nb_ur_ack", nb_ack, 1);
        check("nb_ur_oe", nb_rdata_oe, 1);
        check("nb_ur_rdata", nb_rdata, 16'h0000);
        check("nb_ur_status", nb_status, 3'b001);
        nb_read = 1'b0; tick();
        for (int i = 0; i < 4; i++) begin
            nb_write = 1'b1; nb_wdata = 16'hA0 + 16'(i); tick();
            check("nb_wr_ack", nb_ack, 1);
            nb_write = 1'b0; tick();
        end
        check("nb_full_count", nb_out_count, 4);
        nb_write = 1'b1; nb_wdata = 16'hBAD0; tick();
        check("nb_ov_ack", nb_ack, 1);
        check("nb_ov_status", nb_status, 3'b011);
        check("nb_ov_count", nb_out_count, 4);
        nb_write = 1'b0; tick();
        nb_clr = 1'b1; nb_read = 1'b1; tick();
        check("nb_clr_set_wins", nb_status, 3'b001);
        nb_clr = 1'b0; nb_read = 1'b0; tick();
        nb_clr = 1'b1; tick();
        nb_clr = 1'b0;
        check("nb_clr", nb_status, 3'b000);
        check("nb_out_valid", nb_out_valid, 1);
        nb_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("nb_drain%0d", i), nb_out_data, 16'hA0 + 16'(i));
            tick();
        end
        nb_out_ready = 1'b0;
        check("nb_dropped", nb_out_count, 0);

        // Random traffic on the blocking instance against queue-based ordering model.
        cpu_op = 0; wait_cnt = 0;
        q_in.delete(); q_out.delete();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cpu_op == 0 && !ioack && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    io_read = 1'b1; cpu_op = 1;
                end else begin
                    io_write = 1'b1; io_wdata = 16'($urandom); cpu_op = 2;
                end
                wait_cnt = 0;
            end
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            check("rnd_in_ready", in_ready, q_in.size() < 16);
            check("rnd_in_count", in_count, q_in.size());
            check("rnd_out_count", out_count, q_out.size());
            check("rnd_out_valid", out_valid, q_out.size() != 0);
            if (in_valid && in_ready) q_in.push_back(in_data);
            if (out_valid && out_ready && q_out.size() != 0) begin
                exp_w = q_out.pop_front();
                check("rnd_out_data", out_data, exp_w);
            end
            tick();
            if (cpu_op != 0) begin
                if (ioack) begin
                    if (cpu_op == 1) begin
                        check("rnd_rd_nonempty", q_in.size() != 0, 1);
                        if (q_in.size() != 0) begin
                            exp_w = q_in.pop_front();
                            check("rnd_rdata", io_rdata, exp_w);
                        end
                    end else begin
                        q_out.push_back(io_wdata);
                    end
                    io_read = 1'b0; io_write = 1'b0; cpu_op = 0;
                end else begin
                    wait_cnt++;
                    if (wait_cnt > 200) begin
                        check("rnd_ack_timeout", 0, 1);
                        io_read = 1'b0; io_write = 1'b0; cpu_op = 0;
                    end
                end
            end
        end
        {io_read, io_write, in_valid, out_ready} = '0;
        tick(); tick();
        check("rnd_status", status, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
